// File: rtl/render_pkg.sv
// -----------------------------------------------------------------------------
// render_pkg
// Shared definitions for the node sprite renderer:
//   - 3-bit colour constants
//   - RENDER_LATENCY: fixed pixel-to-colour pipeline depth
//   - sq_dist(): squared Euclidean distance.
//     It is computed on a wide intermediate so that no product or sum can be
//     truncated for any supported coordinate width.
// -----------------------------------------------------------------------------
package render_pkg;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;

    localparam int RENDER_LATENCY = 3;

    // Callers sign-extend their (COORD_W+2)-bit deltas into 32 bits.
    function automatic logic [63:0] sq_dist(input logic signed [31:0] dx,
                                            input logic signed [31:0] dy);
        logic signed [63:0] dx_w;
        logic signed [63:0] dy_w;
        dx_w = 64'(dx);
        dy_w = 64'(dy);
        return $unsigned(dx_w * dx_w + dy_w * dy_w);
    endfunction

endpackage

// File: rtl/node_hit_test.sv
// -----------------------------------------------------------------------------
// node_hit_test
// Two-stage hit test of one pixel against one circular node.
//   Stage 1: signed deltas from the circle centre (pos + RADIUS) to the pixel.
//   Stage 2: hit = en && dx^2 + dy^2 <= RADIUS^2.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   pos_x, pos_y  : node bounding-box top-left (already snapshot/bypassed)
//   en            : node draw enable (already snapshot/bypassed)
//   pix_x, pix_y  : current pixel
//   hit           : registered hit, two cycles after pix
// -----------------------------------------------------------------------------
module node_hit_test
    import render_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int RADIUS  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               en,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               hit
);

    // Two extra bits: one for the +RADIUS carry, one for the sign.
    // This way the centre of a node near the right/bottom edge never wraps.
    localparam int DW = COORD_W + 2;
    localparam logic signed [DW-1:0] RAD_S  = DW'(RADIUS);
    localparam logic [63:0]          RAD_SQ = 64'(RADIUS * RADIUS);

    logic signed [DW-1:0] dx_next;
    logic signed [DW-1:0] dy_next;
    logic signed [DW-1:0] dx_reg;
    logic signed [DW-1:0] dy_reg;
    logic                 en_reg;
    logic                 hit_reg;

    always_comb begin
        dx_next = $signed({2'b00, pos_x}) + RAD_S - $signed({2'b00, pix_x});
        dy_next = $signed({2'b00, pos_y}) + RAD_S - $signed({2'b00, pix_y});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_reg  <= '0;
            dy_reg  <= '0;
            en_reg  <= 1'b0;
            hit_reg <= 1'b0;
        end else begin
            dx_reg  <= dx_next;
            dy_reg  <= dy_next;
            en_reg  <= en;
            hit_reg <= en_reg && (sq_dist(32'(dx_reg), 32'(dy_reg)) <= RAD_SQ);
        end
    end

    assign hit = hit_reg;

endmodule

// File: rtl/node_sprite_renderer.sv
// -----------------------------------------------------------------------------
// node_sprite_renderer
// Draws NUM_NODES filled circles over a background, one RGB value per pixel
// clock, with a fixed three-cycle latency from pix_x/pix_y to graph_rgb.
//
// Node positions are snapshotted into shadow registers on frame_start.
// This lets the rope simulator update mid-frame without tearing. The pixel
// presented with frame_start already sees the new snapshot, because the
// hit testers read the next-state values through a bypass.
//
// Ports:
//   clk, reset         : pixel clock, synchronous active-high reset
//   frame_start        : one-cycle pulse at the first pixel of a frame
//   video_on           : pixel is in the active area
//   pix_x, pix_y       : current pixel
//   nodes_x, nodes_y   : packed node positions, node i at [i*COORD_W +: COORD_W]
//   node_en            : per-node draw enable
//   graph_rgb          : pixel colour, three cycles after its pixel
//   hit_valid          : output pixel lies on an enabled node
//   hit_index          : lowest-index node hit (0 when no hit)
// -----------------------------------------------------------------------------
module node_sprite_renderer
    import render_pkg::*;
#(
    parameter int               NUM_NODES  = 20,
    parameter int               COORD_W    = 10,
    parameter int               RADIUS     = 5,
    parameter int               RGB_W      = 3,
    parameter logic [RGB_W-1:0] BG_COLOR   = RGB_W'(WHITE),
    parameter logic [RGB_W-1:0] NODE_COLOR = RGB_W'(BLUE),
    parameter logic [RGB_W-1:0] HEAD_COLOR = RGB_W'(GREEN),
    localparam int              LATENCY    = RENDER_LATENCY,
    localparam int              IDX_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           video_on,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    input  logic [NUM_NODES*COORD_W-1:0]   nodes_x,
    input  logic [NUM_NODES*COORD_W-1:0]   nodes_y,
    input  logic [NUM_NODES-1:0]           node_en,
    output logic [RGB_W-1:0]               graph_rgb,
    output logic                           hit_valid,
    output logic [IDX_W-1:0]               hit_index
);

    logic [NUM_NODES*COORD_W-1:0] shadow_x_reg;
    logic [NUM_NODES*COORD_W-1:0] shadow_y_reg;
    logic [NUM_NODES-1:0]         shadow_en_reg;

    logic [NUM_NODES*COORD_W-1:0] eff_x;
    logic [NUM_NODES*COORD_W-1:0] eff_y;
    logic [NUM_NODES-1:0]         eff_en;

    logic                         video_d1_reg;
    logic                         video_d2_reg;
    logic [NUM_NODES-1:0]         hit_vec;

    logic [RGB_W-1:0]             rgb_reg;
    logic [RGB_W-1:0]             rgb_next;
    logic                         hit_valid_reg;
    logic                         hit_valid_next;
    logic [IDX_W-1:0]             hit_index_reg;
    logic [IDX_W-1:0]             hit_index_next;

    // Snapshot bypass: on a frame_start cycle the testers see the incoming
    // positions directly, matching what the shadows hold from the next edge on.
    assign eff_x  = frame_start ? nodes_x : shadow_x_reg;
    assign eff_y  = frame_start ? nodes_y : shadow_y_reg;
    assign eff_en = frame_start ? node_en : shadow_en_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_x_reg  <= '0;
            shadow_y_reg  <= '0;
            shadow_en_reg <= '0;
        end else if (frame_start) begin
            shadow_x_reg  <= nodes_x;
            shadow_y_reg  <= nodes_y;
            shadow_en_reg <= node_en;
        end
    end

    // video_on follows the two hit-test stages so it lines up with hit_vec.
    always_ff @(posedge clk) begin
        if (reset) begin
            video_d1_reg <= 1'b0;
            video_d2_reg <= 1'b0;
        end else begin
            video_d1_reg <= video_on;
            video_d2_reg <= video_d1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
            node_hit_test #(
                .COORD_W (COORD_W),
                .RADIUS  (RADIUS)
            ) u_hit (
                .clk   (clk),
                .reset (reset),
                .pos_x (eff_x[gi*COORD_W +: COORD_W]),
                .pos_y (eff_y[gi*COORD_W +: COORD_W]),
                .en    (eff_en[gi]),
                .pix_x (pix_x),
                .pix_y (pix_y),
                .hit   (hit_vec[gi])
            );
        end
    endgenerate

    // Priority encode and colour select. Scanning downwards leaves the lowest
    // set index, so the lowest-index node wins wherever circles overlap.
    always_comb begin
        hit_index_next = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_index_next = IDX_W'(i);
            end
        end

        hit_valid_next = 1'b0;
        rgb_next       = '0;
        if (!video_d2_reg) begin
            hit_index_next = '0;
        end else if (|hit_vec) begin
            hit_valid_next = 1'b1;
            rgb_next       = (hit_index_next == '0) ? HEAD_COLOR : NODE_COLOR;
        end else begin
            rgb_next       = BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg       <= '0;
            hit_valid_reg <= 1'b0;
            hit_index_reg <= '0;
        end else begin
            rgb_reg       <= rgb_next;
            hit_valid_reg <= hit_valid_next;
            hit_index_reg <= hit_index_next;
        end
    end

    assign graph_rgb = rgb_reg;
    assign hit_valid = hit_valid_reg;
    assign hit_index = hit_index_reg;

endmodule

// File: tb/tb_node_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_node_sprite_renderer
// Directed stimulus for node_sprite_renderer with a behavioural reference.
// The model keeps the per-frame node snapshot as integers. For each pixel it
// computes the expected colour from the circle equation, then delays that
// expectation by three cycles. A per-cycle compare checks the DUT against the
// model. Hand-computed literal checks pin the model at the key geometry points.
// -----------------------------------------------------------------------------
module tb_node_sprite_renderer;

    localparam int N  = 20;
    localparam int CW = 10;
    localparam int R  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              video_on;
    logic [CW-1:0]     pix_x;
    logic [CW-1:0]     pix_y;
    logic [N*CW-1:0]   nodes_x;
    logic [N*CW-1:0]   nodes_y;
    logic [N-1:0]      node_en;
    logic [2:0]        graph_rgb;
    logic              hit_valid;
    logic [4:0]        hit_index;

    node_sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .nodes_x     (nodes_x),
        .nodes_y     (nodes_y),
        .node_en     (node_en),
        .graph_rgb   (graph_rgb),
        .hit_valid   (hit_valid),
        .hit_index   (hit_index)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Node table that the bench drives onto the packed buses.
    int nx [N];
    int ny [N];
    bit ne [N];

    // Model state: the frame snapshot and a three-deep expectation delay line.
    int sx [N];
    int sy [N];
    bit se [N];
    int e_rgb [3];
    int e_val [3];
    int e_idx [3];

    task automatic apply_nodes();
        for (int i = 0; i < N; i++) begin
            nodes_x[i*CW +: CW] = CW'(nx[i]);
            nodes_y[i*CW +: CW] = CW'(ny[i]);
            node_en[i]          = ne[i];
        end
    endtask

    function automatic void model_pixel(input bit vo, input int px, input int py,
                                        output int r, output int v, output int idx);
        r = 0; v = 0; idx = 0;
        if (vo) begin
            r = 7;
            for (int i = 0; i < N; i++) begin
                int dx;
                int dy;
                dx = sx[i] + R - px;
                dy = sy[i] + R - py;
                if (se[i] && (dx*dx + dy*dy <= R*R)) begin
                    v = 1; idx = i; r = (i == 0) ? 2 : 1;
                    break;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                sx[i] = 0; sy[i] = 0; se[i] = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                e_rgb[k] = 0; e_val[k] = 0; e_idx[k] = 0;
            end
        end else begin
            int r, v, idx;
            if (frame_start) begin
                for (int i = 0; i < N; i++) begin
                    sx[i] = int'(nodes_x[i*CW +: CW]);
                    sy[i] = int'(nodes_y[i*CW +: CW]);
                    se[i] = node_en[i];
                end
            end
            model_pixel(video_on, int'(pix_x), int'(pix_y), r, v, idx);
            for (int k = 2; k > 0; k--) begin
                e_rgb[k] = e_rgb[k-1]; e_val[k] = e_val[k-1]; e_idx[k] = e_idx[k-1];
            end
            e_rgb[0] = r; e_val[0] = v; e_idx[0] = idx;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if (int'(graph_rgb) != e_rgb[2] || int'(hit_valid) != e_val[2] ||
                int'(hit_index) != e_idx[2]) begin
                nerr++;
                $display("FAIL model t=%0t: got rgb=%0d valid=%0d idx=%0d, expected rgb=%0d valid=%0d idx=%0d",
                         $time, graph_rgb, hit_valid, hit_index, e_rgb[2], e_val[2], e_idx[2]);
            end
        end
    end

    task automatic check_lit(input string name, input int rgb, input int val, input int idx);
        nvec++;
        if (int'(graph_rgb) != rgb || int'(hit_valid) != val || int'(hit_index) != idx) begin
            nerr++;
            $display("FAIL %s: got rgb=%0d valid=%0d idx=%0d, expected rgb=%0d valid=%0d idx=%0d",
                     name, graph_rgb, hit_valid, hit_index, rgb, val, idx);
        end else begin
            $display("ok   %s: rgb=%0d valid=%0d idx=%0d", name, graph_rgb, hit_valid, hit_index);
        end
    endtask

    task automatic set_pix(input int x, input int y, input bit vo);
        pix_x = CW'(x); pix_y = CW'(y); video_on = vo;
    endtask

    // Hold a pixel long enough for the pipeline to settle, then check it.
    task automatic hold_check(input string name, input int x, input int y, input bit vo,
                              input int rgb, input int val, input int idx);
        set_pix(x, y, vo);
        repeat (4) @(negedge clk);
        check_lit(name, rgb, val, idx);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            nx[i] = 0; ny[i] = 0; ne[i] = 1'b0;
        end
        apply_nodes();
        reset = 1'b1; frame_start = 1'b0;
        set_pix(0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset_state", 0, 0, 0);
        reset = 1'b0;
        video_on = 1'b1;

        // Basic geometry, node0 at (100,50) -> centre (105,55).
        nx[0] = 100; ny[0] = 50; ne[0] = 1'b1;
        apply_nodes();
        pulse_fs();
        hold_check("head_centre", 105, 55, 1'b1, 2, 1, 0);
        hold_check("head_edge_d25", 110, 55, 1'b1, 2, 1, 0);
        hold_check("miss_d36", 111, 55, 1'b1, 7, 0, 0);
        hold_check("miss_d32", 109, 59, 1'b1, 7, 0, 0);

        // Overlap: node2 and node5 share a position.
        nx[2] = 300; ny[2] = 200; ne[2] = 1'b1;
        nx[5] = 300; ny[5] = 200; ne[5] = 1'b1;
        apply_nodes();
        pulse_fs();
        hold_check("overlap_low", 305, 205, 1'b1, 1, 1, 2);
        ne[2] = 1'b0;
        apply_nodes();
        pulse_fs();
        hold_check("overlap_n2_off", 305, 205, 1'b1, 1, 1, 5);

        // Snapshot timing on node3.
        nx[3] = 400; ny[3] = 100; ne[3] = 1'b1;
        apply_nodes();
        pulse_fs();
        hold_check("snap_old", 405, 105, 1'b1, 1, 1, 3);
        nx[3] = 500;
        apply_nodes();
        hold_check("snap_held_old", 405, 105, 1'b1, 1, 1, 3);
        hold_check("snap_held_new", 505, 105, 1'b1, 7, 0, 0);
        // Same-cycle bypass: frame_start with the new centre, exactly 3 cycles.
        frame_start = 1'b1;
        set_pix(505, 105, 1'b1);
        @(negedge clk);
        frame_start = 1'b0;
        video_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_lit("bypass_lat3", 1, 1, 3);
        hold_check("snap_old_gone", 405, 105, 1'b1, 7, 0, 0);

        // Edge arithmetic.
        nx[1] = 0; ny[1] = 0; ne[1] = 1'b1;
        nx[4] = 1023; ny[4] = 300; ne[4] = 1'b1;
        nx[6] = 600; ny[6] = 1023; ne[6] = 1'b1;
        apply_nodes();
        pulse_fs();
        hold_check("origin_d50", 0, 0, 1'b1, 7, 0, 0);
        hold_check("origin_hit", 5, 0, 1'b1, 1, 1, 1);
        hold_check("xwrap_miss", 0, 305, 1'b1, 7, 0, 0);
        hold_check("xmax_hit", 1023, 305, 1'b1, 1, 1, 4);
        hold_check("ywrap_miss", 605, 0, 1'b1, 7, 0, 0);

        // Blanking over a hit.
        hold_check("blank_hit", 105, 55, 1'b0, 0, 0, 0);

        // Raster sweep around node0 and node3 with intermittent blanking;
        // the per-cycle compare checks every pixel against the model.
        for (int y = 49; y <= 61; y++) begin
            for (int x = 98; x <= 113; x++) begin
                set_pix(x, y, ((x + y) % 7) != 0);
                @(negedge clk);
            end
        end
        for (int y = 98; y <= 112; y++) begin
            for (int x = 498; x <= 512; x++) begin
                set_pix(x, y, 1'b1);
                @(negedge clk);
            end
        end

        // Reset mid-line.
        hold_check("pre_reset_hit", 105, 55, 1'b1, 2, 1, 0);
        reset = 1'b1;
        @(negedge clk);
        check_lit("reset_mid", 0, 0, 0);
        reset = 1'b0;
        hold_check("post_reset_bg", 105, 55, 1'b1, 7, 0, 0);
        hold_check("post_reset_bg2", 505, 105, 1'b1, 7, 0, 0);
        // Reset and frame_start together: reset wins, shadows stay clear.
        reset = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        reset = 1'b0; frame_start = 1'b0;
        hold_check("reset_beats_fs", 105, 55, 1'b1, 7, 0, 0);
        pulse_fs();
        hold_check("refill_hit", 105, 55, 1'b1, 2, 1, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
